pipe_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage RV32 pipeline. It drives the enable and synchronous-clear inputs of the PC register and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves four conditions: load-use stalls, taken-branch flushes, multi-cycle data-memory waits with timeout, and halting on a system instruction reaching WB. Each stage's clear output is ANDed with rst at the latch's rst pin.

---
 rtl/pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: drives the PC and inter-stage latch enables and bubble clears.
// It handles load-use stalls, taken-branch flushes, data-memory waits with timeout, and system-instruction halt.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_sysi,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_clr_n,
  output logic             id_ex_clr_n,
  output logic             ex_mem_clr_n,
  output logic             mem_wb_clr_n,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // state      | meaning
  // S_RUN      | normal flow; branch flush and load-use stall resolved here
  // S_MEM_WAIT | data memory busy; front of pipe frozen, bubbles enter WB
  // S_HALT     | all latches frozen until a resume pulse

  localparam int unsigned WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WC_W-1:0]   r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_lu;
  logic w_ms;
  logic w_timeout;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_id_ex_en;
  logic w_ex_mem_en;
  logic w_mem_wb_en;
  logic w_if_id_clr_n;
  logic w_id_ex_clr_n;
  logic w_ex_mem_clr_n;
  logic w_mem_wb_clr_n;

  assign w_lu = ex_is_load && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign w_ms = mem_req && !mem_ready;

  // Timeout is judged only on MEM_WAIT cycles; the RUN cycle that raises the wait is not counted.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_state == S_MEM_WAIT) && w_ms &&
                     (r_wait_cnt == WC_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_id_ex_en     = 1'b1;
    w_ex_mem_en    = 1'b1;
    w_mem_wb_en    = 1'b1;
    w_if_id_clr_n  = 1'b1;
    w_id_ex_clr_n  = 1'b1;
    w_ex_mem_clr_n = 1'b1;
    w_mem_wb_clr_n = 1'b1;

    if (!rst) begin
      w_state_nxt    = S_RUN;
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wb_en    = 1'b0;
      w_if_id_clr_n  = 1'b0;
      w_id_ex_clr_n  = 1'b0;
      w_ex_mem_clr_n = 1'b0;
      w_mem_wb_clr_n = 1'b0;
    end else begin
      case (r_state)
        S_HALT: begin
          if (resume) begin
            w_state_nxt = S_RUN;
          end else begin
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
          end
        end
        S_RUN, S_MEM_WAIT: begin
          if ((r_state == S_RUN) && wb_sysi) begin
            w_state_nxt = S_HALT;
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
          end else if (w_ms) begin
            w_state_nxt    = w_timeout ? S_HALT : S_MEM_WAIT;
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_clr_n = 1'b0;
          end else begin
            // Wait release cycle behaves as RUN, so a branch held during the wait flushes here.
            w_state_nxt = S_RUN;
            if (ex_br_taken) begin
              w_if_id_clr_n = 1'b0;
              w_id_ex_clr_n = 1'b0;
            end else if (w_lu) begin
              w_pc_en       = 1'b0;
              w_if_id_en    = 1'b0;
              w_id_ex_clr_n = 1'b0;
            end
          end
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_MEM_WAIT) && (w_state_nxt == S_MEM_WAIT)) begin
        if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + WC_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout) r_mem_err <= 1'b1;
      if (!w_pc_en && (r_state != S_HALT) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign pc_en        = w_pc_en;
  assign if_id_en     = w_if_id_en;
  assign id_ex_en     = w_id_ex_en;
  assign ex_mem_en    = w_ex_mem_en;
  assign mem_wb_en    = w_mem_wb_en;
  assign if_id_clr_n  = w_if_id_clr_n;
  assign id_ex_clr_n  = w_id_ex_clr_n;
  assign ex_mem_clr_n = w_ex_mem_clr_n;
  assign mem_wb_clr_n = w_mem_wb_clr_n;
  assign halted       = (r_state == S_HALT);
  assign mem_err      = r_mem_err;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TO      = 4;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;
  logic          mem_req, mem_ready, wb_sysi, resume;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_clr_n, id_ex_clr_n, ex_mem_clr_n, mem_wb_clr_n;
  logic          halted, mem_err;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .wb_sysi(wb_sysi), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_clr_n(if_id_clr_n), .id_ex_clr_n(id_ex_clr_n),
    .ex_mem_clr_n(ex_mem_clr_n), .mem_wb_clr_n(mem_wb_clr_n),
    .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: halted flag, in-wait flag with count of completed wait cycles
  bit m_halt, m_in_wait, m_err;
  int m_wait_cycles, m_stalls;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic idle();
    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    wb_sysi = 1'b0; resume = 1'b0;
  endtask

  // Compare current outputs with the model, advance the model, then cross one clock edge.
  task automatic step();
    logic [8:0] exp;
    bit lu, ms;
    #1;
    lu = ex_is_load && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    ms = mem_req && !mem_ready;
    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb clears}
    if (!rst)                          exp = 9'b00000_0000;
    else if (m_halt)                   exp = resume ? 9'b11111_1111 : 9'b00000_1111;
    else if (!m_in_wait && wb_sysi)    exp = 9'b00000_1111;
    else if (ms)                       exp = 9'b00001_1110;
    else if (ex_br_taken)              exp = 9'b11111_0011;
    else if (lu)                       exp = 9'b00111_1011;
    else                               exp = 9'b11111_1111;
    check("en_clr", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                         if_id_clr_n, id_ex_clr_n, ex_mem_clr_n, mem_wb_clr_n}), 32'(exp));
    check("halted", 32'(halted), 32'(m_halt));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));

    if (!rst) begin
      m_halt = 0; m_in_wait = 0; m_err = 0; m_wait_cycles = 0; m_stalls = 0;
    end else begin
      if (!m_halt && exp[8] == 1'b0 && m_stalls < CNT_MAX) m_stalls++;
      if (m_halt) begin
        if (resume) m_halt = 0;
      end else if (!m_in_wait && wb_sysi) begin
        m_halt = 1;
      end else if (ms) begin
        if (m_in_wait && TO != 0 && m_wait_cycles + 1 == TO) begin
          m_halt = 1; m_err = 1; m_in_wait = 0; m_wait_cycles = 0;
        end else if (m_in_wait) begin
          m_wait_cycles++;
        end else begin
          m_in_wait = 1; m_wait_cycles = 0;
        end
      end else begin
        m_in_wait = 0; m_wait_cycles = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b0; step(); step(); idle();
  endtask

  initial begin
    m_halt = 0; m_in_wait = 0; m_err = 0; m_wait_cycles = 0; m_stalls = 0;
    idle(); rst = 1'b0;
    @(posedge clk); #1;
    do_reset();
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // load-use on rs2
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; step();
    idle(); step();
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // branch with simultaneous load-use: branch wins, no stall counted
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; ex_br_taken = 1'b1; step();
    idle();
    check("br_lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // x0 load destination never stalls
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; step();
    idle();

    // three memory-wait cycles then ready
    do_reset();
    for (int i = 0; i < 3; i++) begin mem_req = 1'b1; mem_ready = 1'b0; step(); end
    mem_req = 1'b1; mem_ready = 1'b1; step();
    idle();
    check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    check("mw_halted", 32'(halted), 32'd0);

    // timeout: one RUN cycle plus four MEM_WAIT cycles lands in HALT
    for (int i = 0; i < 5; i++) begin mem_req = 1'b1; mem_ready = 1'b0; step(); end
    check("to_halted", 32'(halted), 32'd1);
    check("to_mem_err", 32'(mem_err), 32'd1);
    idle(); resume = 1'b1; step();
    idle(); step();
    check("to_resume_halted", 32'(halted), 32'd0);
    check("to_err_sticky", 32'(mem_err), 32'd1);

    // system instruction halt and resume with wb_sysi held
    wb_sysi = 1'b1; step();
    check("sysi_halted", 32'(halted), 32'd1);
    step(); step();
    resume = 1'b1; step();
    check("sysi_resume_halted", 32'(halted), 32'd0);
    idle(); step();

    // reset in the middle of a wait clears sticky error and counter
    mem_req = 1'b1; mem_ready = 1'b0; step(); step();
    rst = 1'b0; step();
    check("rmw_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rmw_mem_err", 32'(mem_err), 32'd0);
    idle(); step();

    // random traffic, includes counter saturation and occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) != 0);
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = ($urandom_range(0, 1) == 1);
      id_use_rs2  = ($urandom_range(0, 1) == 1);
      ex_is_load  = ($urandom_range(0, 1) == 1);
      ex_br_taken = ($urandom_range(0, 6) == 0);
      mem_req     = ($urandom_range(0, 9) < 3);
      mem_ready   = ($urandom_range(0, 9) < 4);
      wb_sysi     = ($urandom_range(0, 29) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
